// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory / write-back stage of the ARM-style pipeline.
// Performs a single-word data-memory access over a req/ready handshake,
// freezing upstream while the access is outstanding, and drives the
// register-file write port from registers.
// Optional feature macro: MEM_WB_FORWARD_EN adds fwd_valid/fwd_dest/fwd_value
// mirrors of the write-back port for the EX-stage forwarding unit.
module mem_wb_stage #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic [3:0]  dest_in,
  input  logic [31:0] alu_res_in,
  input  logic [31:0] st_val_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        freeze,
  output logic        writeBackEn,
  output logic [3:0]  Dest_wb,
  output logic [31:0] Result_WB,
`ifdef MEM_WB_FORWARD_EN
  output logic        mem_err,
  output logic        fwd_valid,
  output logic [3:0]  fwd_dest,
  output logic [31:0] fwd_value
`else
  output logic        mem_err
`endif
);

  // A 1-wide counter is the floor; TIMEOUT_CYCLES >= 2 keeps clog2 >= 1.
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          req_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          freeze_q;
  logic          wb_en_q;
  logic [3:0]    dest_wb_q;
  logic [31:0]   result_q;
  logic          err_q;
  // Attributes of the in-flight memory instruction.
  logic [3:0]    lat_dest_q;
  logic          lat_wb_q;
  logic          lat_rd_q;

  // Stage FSM: captures EX/MEM, runs the handshake, updates write-back regs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      freeze_q   <= 1'b0;
      wb_en_q    <= 1'b0;
      dest_wb_q  <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      lat_dest_q <= '0;
      lat_wb_q   <= 1'b0;
      lat_rd_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!in_valid) begin
            wb_en_q <= 1'b0;
          end else if (mem_r_en_in || mem_w_en_in) begin
            lat_dest_q <= dest_in;
            lat_wb_q   <= wb_en_in;
            lat_rd_q   <= mem_r_en_in;
            addr_q     <= alu_res_in;
            wdata_q    <= st_val_in;
            // A write enable wins, so r+w together behaves as a store.
            we_q       <= mem_w_en_in;
            req_q      <= 1'b1;
            freeze_q   <= 1'b1;
            wb_en_q    <= 1'b0;
            cnt_q      <= '0;
            state_q    <= ACCESS;
          end else begin
            wb_en_q   <= wb_en_in;
            dest_wb_q <= dest_in;
            result_q  <= alu_res_in;
          end
        end
        ACCESS: begin
          // Ready is checked before the timeout so a last-cycle ready completes.
          if (dmem_ready) begin
            if (lat_rd_q && !we_q) begin
              result_q  <= dmem_rdata;
              dest_wb_q <= lat_dest_q;
              wb_en_q   <= lat_wb_q;
            end else begin
              wb_en_q <= 1'b0;
            end
            req_q    <= 1'b0;
            freeze_q <= 1'b0;
            state_q  <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            req_q    <= 1'b0;
            freeze_q <= 1'b0;
            err_q    <= 1'b1;
            wb_en_q  <= 1'b0;
            state_q  <= IDLE;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            wb_en_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdata_q;
  assign freeze      = freeze_q;
  assign writeBackEn = wb_en_q;
  assign Dest_wb     = dest_wb_q;
  assign Result_WB   = result_q;
  assign mem_err     = err_q;

`ifdef MEM_WB_FORWARD_EN
  assign fwd_valid = wb_en_q;
  assign fwd_dest  = dest_wb_q;
  assign fwd_value = result_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage (TIMEOUT_CYCLES = 4).
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [3:0]  dest_in;
  logic [31:0] alu_res_in, st_val_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ready;
  logic        freeze, writeBackEn, mem_err;
  logic [3:0]  Dest_wb;
  logic [31:0] Result_WB;

  mem_wb_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .wb_en_in(wb_en_in),
    .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .dest_in(dest_in),
    .alu_res_in(alu_res_in), .st_val_in(st_val_in), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .freeze(freeze),
    .writeBackEn(writeBackEn), .Dest_wb(Dest_wb), .Result_WB(Result_WB),
    .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] dest; logic [31:0] val; } wb_t;
  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } req_t;

  wb_t  wb_q[$];
  req_t req_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_wb_cyc = 0;
  int   prev_wb_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else
      $display("ok   %s: 0x%08h", name, act);
  endtask

  // Write-back monitor: every register-file write must match the next expectation.
  always @(negedge clk) begin
    wb_t e;
    cyc++;
    if (rst === 1'b1 && writeBackEn === 1'b1) begin
      prev_wb_cyc = last_wb_cyc;
      last_wb_cyc = cyc;
      if (wb_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL wb_unexpected: got dest=%0d val=0x%08h expected no write", Dest_wb, Result_WB);
      end else begin
        e = wb_q.pop_front();
        chk("wb_dest", 32'(Dest_wb), 32'(e.dest));
        chk("wb_value", Result_WB, e.val);
      end
    end
  end

  // Memory-request monitor: checks each new request and its stability while held.
  logic req_prev = 1'b0;
  req_t cur_req;
  always @(negedge clk) begin
    if (dmem_req === 1'b1 && !req_prev) begin
      if (req_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL req_unexpected: got addr=0x%08h expected no request", dmem_addr);
      end else begin
        cur_req = req_q.pop_front();
        chk("req_we", 32'(dmem_we), 32'(cur_req.we));
        chk("req_addr", dmem_addr, cur_req.addr);
        chk("req_wdata", dmem_wdata, cur_req.wdata);
      end
    end else if (dmem_req === 1'b1) begin
      chk("req_addr_stable", dmem_addr, cur_req.addr);
      chk("req_we_stable", 32'(dmem_we), 32'(cur_req.we));
    end
    req_prev = (dmem_req === 1'b1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic wb, input logic r, input logic w, input logic [3:0] d,
                       input logic [31:0] alu, input logic [31:0] st);
    in_valid = 1'b1; wb_en_in = wb; mem_r_en_in = r; mem_w_en_in = w;
    dest_in = d; alu_res_in = alu; st_val_in = st;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; wb_en_in = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
  endtask

  // Memory op: capture, then n ACCESS cycles; ready in the last one if give_ready.
  task automatic mem_op(input logic wb, input logic r, input logic w, input logic [3:0] d,
                        input logic [31:0] addr, input logic [31:0] st,
                        input int n, input logic give_ready, input logic [31:0] rdata);
    drive(wb, r, w, d, addr, st);
    tick();
    idle_in();
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      chk("freeze_in_access", 32'(freeze), 32'd1);
      chk("req_in_access", 32'(dmem_req), 32'd1);
      if (k == n && give_ready) begin
        dmem_ready = 1'b1; dmem_rdata = rdata;
      end
      tick();
      dmem_ready = 1'b0;
    end
    @(negedge clk);
    chk("freeze_after", 32'(freeze), 32'd0);
    chk("req_after", 32'(dmem_req), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, 32'(dmem_req), 0);
    chk({tag, "_we"}, 32'(dmem_we), 0);
    chk({tag, "_addr"}, dmem_addr, 0);
    chk({tag, "_wdata"}, dmem_wdata, 0);
    chk({tag, "_freeze"}, 32'(freeze), 0);
    chk({tag, "_wben"}, 32'(writeBackEn), 0);
    chk({tag, "_dest"}, 32'(Dest_wb), 0);
    chk({tag, "_result"}, Result_WB, 0);
    chk({tag, "_err"}, 32'(mem_err), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0; tick(); tick(); rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; idle_in(); dest_in = 0; alu_res_in = 0; st_val_in = 0;
    dmem_ready = 1'b0; dmem_rdata = 0;
    tick(); tick();
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;

    // Non-memory write to r3.
    wb_q.push_back('{dest: 4'd3, val: 32'h0000_00AA});
    drive(1, 0, 0, 4'd3, 32'h0000_00AA, 0);
    tick(); idle_in();
    @(negedge clk);
    chk("alu_wben", 32'(writeBackEn), 1);
    chk("alu_freeze", 32'(freeze), 0);
    tick();

    // Load r5 from 0x40, ready in 3rd ACCESS cycle.
    req_q.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0});
    wb_q.push_back('{dest: 4'd5, val: 32'hDEAD_BEEF});
    mem_op(1, 1, 0, 4'd5, 32'h40, 0, 3, 1, 32'hDEAD_BEEF);
    chk("load_wben", 32'(writeBackEn), 1);
    tick();

    // Store 0x1234 to 0x80, ready in 2nd cycle; no write-back.
    req_q.push_back('{we: 1'b1, addr: 32'h80, wdata: 32'h1234});
    mem_op(0, 0, 1, 4'd1, 32'h80, 32'h1234, 2, 1, 32'h0);
    chk("store_wben", 32'(writeBackEn), 0);
    tick();

    // Timeout: load, ready never arrives within 4 cycles.
    req_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0});
    mem_op(1, 1, 0, 4'd9, 32'h100, 0, 4, 0, 32'h0);
    chk("timeout_err", 32'(mem_err), 1);
    chk("timeout_wben", 32'(writeBackEn), 0);
    tick();

    // Ready exactly in the 4th cycle completes with no error.
    do_reset();
    req_q.push_back('{we: 1'b0, addr: 32'h104, wdata: 32'h0});
    wb_q.push_back('{dest: 4'd6, val: 32'hCAFE_0004});
    mem_op(1, 1, 0, 4'd6, 32'h104, 0, 4, 1, 32'hCAFE_0004);
    chk("ready4_err", 32'(mem_err), 0);
    tick();

    // Reset in the 2nd ACCESS cycle; late ready must not write back.
    req_q.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0});
    drive(1, 1, 0, 4'd4, 32'h200, 0);
    tick(); idle_in();
    tick();
    rst = 1'b0; tick(); rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    dmem_ready = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
    tick(); dmem_ready = 1'b0;
    @(negedge clk);
    chk("late_ready_wben", 32'(writeBackEn), 0);
    tick();

    // Load r2 then a held ALU op to r7.
    req_q.push_back('{we: 1'b0, addr: 32'h44, wdata: 32'h0});
    wb_q.push_back('{dest: 4'd2, val: 32'h0000_0055});
    wb_q.push_back('{dest: 4'd7, val: 32'h0000_0077});
    drive(1, 1, 0, 4'd2, 32'h44, 0);
    tick();
    drive(1, 0, 0, 4'd7, 32'h77, 0);
    tick();
    dmem_ready = 1'b1; dmem_rdata = 32'h55;
    tick(); dmem_ready = 1'b0;
    // Upstream releases the op after the first unfrozen capture edge.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!freeze) begin
        tick(); idle_in(); break;
      end
      tick();
    end
    idle_in();
    tick(); tick();
    chk("b2b_spacing", 32'(last_wb_cyc - prev_wb_cyc), 32'd1);

    chk("wb_queue_empty", 32'(wb_q.size()), 0);
    chk("req_queue_empty", 32'(req_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory/write-back stage of the ARM-style pipeline. Captures instructions leaving EX/MEM and performs the single-word data-memory access through a request/ready handshake, freezing upstream stages while the access is in flight. Drives the register file's write port (`writeBackEn`, `Dest_wb`, `Result_WB`) from registers, so the value is stable for the whole cycle in which the register file writes it on the falling edge.

## Interface
- `TIMEOUT_CYCLES`, 64: ACCESS cycles allowed before the access is aborted; legal range 2..65535.
- `clk`  input  1  pipeline clock; all state updates on the rising edge.
- `rst`  input  1  reset; synchronous, active-low. One clock; reset is synchronous and active-low.
- `in_valid`  input  1  EX/MEM holds a valid instruction.
- `wb_en_in`  input  1  instruction writes a register.
- `mem_r_en_in`  input  1  load.
- `mem_w_en_in`  input  1  store.
- `dest_in`  input  4  destination register.
- `alu_res_in`  input  32  ALU result; this is also the memory address.
- `st_val_in`  input  32  store data.
- `dmem_req`  output  1  memory request, held high for the whole access.
- `dmem_we`  output  1  1 = write, 0 = read.
- `dmem_addr`  output  32  word address.
- `dmem_wdata`  output  32  store data.
- `dmem_rdata`  input  32  read data, valid when `dmem_ready` = 1.
- `dmem_ready`  input  1  single-cycle completion pulse.
- `freeze`  output  1  holds IF through EX/MEM.
- `writeBackEn`  output  1  register-file write enable.
- `Dest_wb`  output  4  register-file write index.
- `Result_WB`  output  32  register-file write data.
- `mem_err`  output  1  sticky timeout flag.

## Operation
- **States:** IDLE and ACCESS. Reset puts the block in IDLE.
- **IDLE, `in_valid` = 0:** `writeBackEn` <= 0.
- **IDLE, valid non-memory instruction:**
  - `writeBackEn` <= `wb_en_in`
  - `Dest_wb` <= `dest_in`
  - `Result_WB` <= `alu_res_in`
- **IDLE, valid load or store:**
  - Latch `dest_in`, `wb_en_in` and `mem_r_en_in`.
  - `dmem_addr` <= `alu_res_in`, `dmem_wdata` <= `st_val_in`, `dmem_we` <= `mem_w_en_in`.
  - `dmem_req` <= 1, `writeBackEn` <= 0, timeout counter <= 0; go to ACCESS.
- **Both `mem_r_en_in` and `mem_w_en_in` set:** treated as a store.
- **ACCESS, `dmem_ready` = 0:**
  - Counter increments; `writeBackEn` stays 0.
  - EX/MEM inputs are ignored, because upstream is frozen.
- **ACCESS, `dmem_ready` = 1:**
  - Load: `Result_WB` <= `dmem_rdata`, `Dest_wb` <= latched dest, `writeBackEn` <= latched `wb_en`.
  - Store: `writeBackEn` <= 0.
  - In both cases `dmem_req` <= 0 and the state returns to IDLE.
- **ACCESS timeout:** counter = `TIMEOUT_CYCLES`-1 with no ready in that cycle.
  - `dmem_req` <= 0, `mem_err` <= 1, no write-back; return to IDLE.
  - Ready in that same cycle takes priority: the access completes normally and no error is raised.
- **Ready outside ACCESS:** `dmem_ready` in IDLE is ignored.
- **`mem_err`:** cleared only by reset.
- **`freeze`:** equals (state == ACCESS) and is a registered output.
- **Widths:** counter width is clog2(`TIMEOUT_CYCLES`). No address translation; `dmem_addr` is the ALU result unchanged.

## Timing
- **Reset values** (`rst` = 0 at a rising edge, regardless of state): all outputs 0, state IDLE, counter 0. Reset during ACCESS abandons the access; `dmem_req` is low on the following cycle.
- **Non-memory instruction:** write-back outputs are valid 1 cycle after capture, with no freeze.
- **Memory instruction accepted at edge E:**
  - `dmem_req` and `freeze` are high from E.
  - If ready is seen in the Nth ACCESS cycle, write-back outputs are valid after edge E+N, and `freeze` and `dmem_req` fall at that same edge.
  - Minimum total stall is N = 1 frozen cycle.
- **Instruction following a memory op:** upstream holds it during ACCESS. It is captured at the first IDLE rising edge after the access completes.
- **Stability:** `dmem_addr`, `dmem_wdata` and `dmem_we` do not change while `dmem_req` is high.
- **Back-to-back loads:** each pays the full handshake; nothing is pipelined.

## Configuration
- **Macro:** `MEM_WB_FORWARD_EN`.
- **Defined:** adds outputs `fwd_valid` (1 bit), `fwd_dest` (4 bits) and `fwd_value` (32 bits), equal to `writeBackEn`, `Dest_wb` and `Result_WB`. The EX-stage forwarding unit uses them to bypass the register file. All three reset to 0.
- **Undefined:** the ports do not exist and hazard handling relies on stalling only.

## Test plan
- **Non-memory write:** ALU op, `dest_in`=3, `alu_res_in`=0x0000_00AA, `wb_en_in`=1 -> next cycle `writeBackEn`=1, `Dest_wb`=3, `Result_WB`=0xAA, `freeze`=0.
- **Load:** load to r5 at address 0x40; memory returns ready on the 3rd ACCESS cycle with `dmem_rdata`=0xDEAD_BEEF -> `freeze` is high for 3 cycles, `dmem_addr`=0x40 throughout, then `writeBackEn`=1, `Dest_wb`=5, `Result_WB`=0xDEADBEEF.
- **Store:** address 0x80, data 0x1234 -> `dmem_we`=1, `dmem_wdata`=0x1234 while `dmem_req` is high; `writeBackEn`=0 throughout.
- **Timeout:** `TIMEOUT_CYCLES`=4, ready never asserted -> `dmem_req` falls after 4 ACCESS cycles, `mem_err`=1, no write-back. A second run with ready exactly in the 4th cycle completes normally with `mem_err`=0.
- **Reset mid-access:** `rst`=0 in the 2nd ACCESS cycle -> next cycle all outputs are 0 and state is IDLE. A late `dmem_ready` after reset causes no write-back.
- **Back-to-back traffic:** load followed by a held ALU op to r7 -> the ALU op is written back exactly 1 cycle after the load's write-back, with no lost or duplicated writes.
